// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth signed multiplier: one Booth step per clock, WIDTH/2 steps per product.
// A start pulse loads the operands in any state, so a new start aborts the operation in flight.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int PW = 2 * WIDTH + 3;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] m_reg;
  logic [PW-1:0]    p_reg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_inc;
  logic             last_step;
  logic             rdy_next;

  logic             do_shift;
  logic             do_add;
  logic             do_sub;
  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    m_sel;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_sum;
  logic signed [PW-1:0] p_sum;
  logic [PW-1:0]    p_step;

  // Booth group P[2:0] decoded to {shift, add, sub}; shift selects 2M over M.
  always_comb begin
    do_shift = 1'b0;
    do_add   = 1'b0;
    do_sub   = 1'b0;
    case (p_reg[2:0])
      3'b001, 3'b010: do_add = 1'b1;
      3'b011: begin do_shift = 1'b1; do_add = 1'b1; end
      3'b100: begin do_shift = 1'b1; do_sub = 1'b1; end
      3'b101, 3'b110: do_sub = 1'b1;
      default: ;
    endcase
  end

  // The accumulator is two bits wider than the operand so 2*(most-negative M) does not wrap.
  always_comb begin
    m_ext   = {{2{m_reg[WIDTH-1]}}, m_reg};
    m_sel   = do_shift ? {m_ext[AW-2:0], 1'b0} : m_ext;
    addend  = do_add ? m_sel : (do_sub ? (~m_sel + 1'b1) : '0);
    acc_sum = p_reg[PW-1:WIDTH+1] + addend;
    p_sum   = {acc_sum, p_reg[WIDTH:0]};
    p_step  = p_sum >>> 2;
  end

  assign count_inc = count + 1'b1;
  assign last_step = (count_inc == LAST_STEP);

  always_comb begin
    state_next = state;
    rdy_next   = 1'b0;
    if (ctrl_MULT) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (last_step) begin
            state_next = DONE;
            rdy_next   = 1'b1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_next;
      data_resultRDY <= rdy_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_reg <= '0;
      p_reg <= '0;
      count <= '0;
    end else if (ctrl_MULT) begin
      m_reg <= data_operandA;
      p_reg <= {{AW{1'b0}}, data_operandB, 1'b0};
      count <= '0;
    end else if (state == RUN) begin
      p_reg <= p_step;
      count <= count_inc;
    end
  end

  // Product sits in P[2*WIDTH:1]; overflow when the upper bits are not a sign extension of bit WIDTH.
  assign data_result    = p_reg[WIDTH:1];
  assign data_exception = ~((&p_reg[PW-1:WIDTH]) | ~(|p_reg[PW-1:WIDTH]));
  assign busy           = (state == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed spec vectors, abort, mid-run reset and randomized
// back-to-back operation against a 64-bit signed arithmetic model.
module tb_booth_mult_seq;
  localparam int W       = 32;
  localparam int LAT     = W / 2;
  localparam int MAX_WAIT = 40;
  localparam int N_RAND  = 2500;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_MULT;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [W:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Reference model: full signed product, low W bits, overflow by range check.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    logic   e;
    p = longint'($signed(x)) * longint'($signed(y));
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return {e, p[W-1:0]};
  endfunction

  // Driver tasks: inputs change on the falling edge, sampled on the next rising edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int k);
    k = 0;
    while (data_resultRDY !== 1'b1 && k < MAX_WAIT) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check_cnt++;
    if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    check_cnt++;
    if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
      $display("FAIL idle_after_reset: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[5] = '{32'd3, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h00010000};
    logic [W-1:0] tb[5] = '{32'd5, 32'h00000006, 32'h00000001, 32'hFFFFFFFF, 32'h00010000};
    logic [W-1:0] tr[5] = '{32'h0000000F, 32'hFFFFFFD6, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    logic         te[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int k;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      check_cnt++;
      if (busy !== 1'b1) $display("FAIL dir_busy[%0d]: got %b expected 1", i, busy);
      else pass_cnt++;
      wait_rdy(k);
      check_cnt++;
      if (k != LAT) $display("FAIL dir_latency[%0d]: got %0d edges expected %0d", i, k, LAT);
      else pass_cnt++;
      check_cnt++;
      if (data_result !== tr[i]) $display("FAIL dir_result[%0d]: got %h expected %h", i, data_result, tr[i]);
      else pass_cnt++;
      check_cnt++;
      if (data_exception !== te[i]) $display("FAIL dir_exc[%0d]: got %b expected %b", i, data_exception, te[i]);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if ({data_resultRDY, busy} !== 2'b00) begin
        $display("FAIL dir_rdy_width[%0d]: got rdy=%b busy=%b expected 0 0", i, data_resultRDY, busy);
      end else pass_cnt++;
      check_cnt++;
      if (data_result !== tr[i]) $display("FAIL dir_hold[%0d]: got %h expected %h", i, data_result, tr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort;
    int k;
    int early_rdy = 0;
    int extra_rdy = 0;
    start_op(32'd1000, 32'd1000);
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) early_rdy++;
    end
    start_op(32'd2, 32'd3);
    wait_rdy(k);
    check_cnt++;
    if (k != LAT) $display("FAIL abort_latency: got %0d edges expected %0d", k, LAT);
    else pass_cnt++;
    check_cnt++;
    if (data_result !== 32'd6 || data_exception !== 1'b0) begin
      $display("FAIL abort_result: got %h exc=%b expected 00000006 exc=0", data_result, data_exception);
    end else pass_cnt++;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) extra_rdy++;
    end
    check_cnt++;
    if (early_rdy + extra_rdy != 0) begin
      $display("FAIL abort_single_rdy: got %0d extra RDY pulses expected 0", early_rdy + extra_rdy);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int k;
    int stray = 0;
    logic [W:0] exp;
    start_op(32'd123, -32'sd45);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    check_cnt++;
    if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
      $display("FAIL midrun_reset: got res=%h exc=%b rdy=%b busy=%b expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end else pass_cnt++;
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) stray++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) stray++;
    end
    check_cnt++;
    if (stray != 0) $display("FAIL midrun_no_rdy: got %0d RDY pulses expected 0", stray);
    else pass_cnt++;
    exp = model(-32'sd321, 32'd77);
    start_op(-32'sd321, 32'd77);
    wait_rdy(k);
    check_cnt++;
    if (k != LAT || {data_exception, data_result} !== exp) begin
      $display("FAIL midrun_fresh: got lat=%0d exc=%b res=%h expected lat=%0d exc=%b res=%h",
               k, data_exception, data_result, LAT, exp[W], exp[W-1:0]);
    end else pass_cnt++;
  endtask

  // Randomized back-to-back: each new start is pulsed in the cycle RDY is high.
  task automatic test_back_to_back;
    logic [W-1:0] corners[5] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [W-1:0] xa[$];
    logic [W-1:0] xb[$];
    logic [W:0]   exp;
    int k;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        xa.push_back(corners[i]);
        xb.push_back(corners[j]);
      end
    for (int i = 0; i < N_RAND; i++) begin
      case ($urandom_range(0, 3))
        0:       begin xa.push_back($urandom); xb.push_back($urandom); end
        1:       begin xa.push_back(W'($signed(16'($urandom)))); xb.push_back(W'($signed(16'($urandom)))); end
        2:       begin xa.push_back(corners[$urandom_range(0, 4)]); xb.push_back($urandom); end
        default: begin xa.push_back($urandom); xb.push_back(corners[$urandom_range(0, 4)]); end
      endcase
    end
    exp_q.push_back(model(xa[0], xb[0]));
    start_op(xa[0], xb[0]);
    for (int i = 0; i < xa.size(); i++) begin
      wait_rdy(k);
      exp = exp_q.pop_front();
      check_cnt++;
      if (k != LAT) $display("FAIL b2b_latency[%0d]: got %0d edges expected %0d", i, k, LAT);
      else pass_cnt++;
      check_cnt++;
      if (data_result !== exp[W-1:0]) begin
        $display("FAIL b2b_result[%0d]: %h*%h got %h expected %h", i, xa[i], xb[i], data_result, exp[W-1:0]);
      end else pass_cnt++;
      check_cnt++;
      if (data_exception !== exp[W]) begin
        $display("FAIL b2b_exc[%0d]: %h*%h got %b expected %b", i, xa[i], xb[i], data_exception, exp[W]);
      end else pass_cnt++;
      if (i + 1 < xa.size()) begin
        exp_q.push_back(model(xa[i+1], xb[i+1]));
        data_operandA = xa[i+1];
        data_operandB = xb[i+1];
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
